// File: rtl/rocket_flight_unit.sv
// rocket_flight_unit
// Per-rocket slave for the rockets controller. It captures the launch bus on a
// rising isActive, moves the rocket vertically once per frame in fixed point,
// flags a border exit back to the controller, and produces a registered
// drawing request with pixel offsets for the VGA mux.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no rocket in flight, waiting for a rising isActive
// FLYING | rocket moving, one speed step per startOfFrame
// DONE   | rocket crossed a border, frozen until the controller releases it

module rocket_flight_unit #(
    parameter int FRAC_BITS     = 6,
    parameter int BORDER_TOP    = 0,
    parameter int BORDER_BOTTOM = 479,
    parameter int ROCKET_W      = 4,
    parameter int ROCKET_H      = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               isActive,
    input  logic signed [10:0] initialSpeed,
    input  logic signed [10:0] initialX,
    input  logic signed [10:0] initialY,
    input  logic signed [10:0] pixelX,
    input  logic signed [10:0] pixelY,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               reachedBorder,
    output logic               drawingRequest,
    output logic        [10:0] offsetX,
    output logic        [10:0] offsetY
);

    localparam int POS_W = 11 + FRAC_BITS;

    // Border limits widened by two bits so Y + height cannot overflow.
    localparam logic signed [12:0] TOP_L    = 13'(BORDER_TOP);
    localparam logic signed [12:0] BOTTOM_L = 13'(BORDER_BOTTOM);
    localparam logic signed [12:0] H_M1_L   = 13'(ROCKET_H - 1);
    localparam logic signed [11:0] W_L      = 12'(ROCKET_W);
    localparam logic signed [11:0] H_L      = 12'(ROCKET_H);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic                     isActive_d;
    logic                     hist_valid;
    logic signed [POS_W-1:0]  posY_fx;
    logic signed [10:0]       speed;
    logic signed [POS_W-1:0]  speed_ext;
    logic signed [POS_W-1:0]  pos_next;
    logic signed [10:0]       y_next;
    logic signed [12:0]       y_next_w;
    logic                     out_of_bounds;
    logic                     do_launch;
    logic                     do_move;
    logic signed [11:0]       dx;
    logic signed [11:0]       dy;
    logic                     in_box;

    // Integer part of the fixed-point position is the reported Y.
    assign topLeftY = posY_fx[POS_W-1:FRAC_BITS];

    // Flag is gated by isActive so it drops the same cycle the controller clears it.
    assign reachedBorder = (state == DONE) && isActive;

    // Candidate position after one frame step and its border test.
    always_comb begin
        speed_ext     = $signed({{FRAC_BITS{speed[10]}}, speed});
        pos_next      = posY_fx + speed_ext;
        y_next        = pos_next[POS_W-1:FRAC_BITS];
        y_next_w      = $signed({{2{y_next[10]}}, y_next});
        out_of_bounds = (y_next_w < TOP_L) || ((y_next_w + H_M1_L) > BOTTOM_L);
    end

    // State register plus isActive history. hist_valid blocks a launch until
    // isActive_d holds a real sample, so isActive already high out of reset
    // is treated as a missed edge rather than a launch.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            isActive_d <= 1'b0;
            hist_valid <= 1'b0;
        end else begin
            state      <= state_n;
            isActive_d <= isActive;
            hist_valid <= 1'b1;
        end
    end

    // Next-state logic; a cleared isActive wins over everything, including movement.
    always_comb begin
        state_n   = state;
        do_launch = 1'b0;
        do_move   = 1'b0;
        if (!isActive) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!isActive_d && hist_valid) begin
                        do_launch = 1'b1;
                        state_n   = FLYING;
                    end
                end
                FLYING: begin
                    if (startOfFrame) begin
                        do_move = 1'b1;
                        if (out_of_bounds) begin
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Position and speed registers: capture on launch, step on each frame in flight.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            posY_fx  <= '0;
            topLeftX <= '0;
            speed    <= '0;
        end else if (do_launch) begin
            posY_fx  <= {initialY, {FRAC_BITS{1'b0}}};
            topLeftX <= initialX;
            speed    <= initialSpeed;
        end else if (do_move) begin
            posY_fx  <= pos_next;
        end
    end

    // Pixel position relative to the rocket box, widened to keep the compare signed-safe.
    always_comb begin
        dx     = $signed({pixelX[10], pixelX}) - $signed({topLeftX[10], topLeftX});
        dy     = $signed({pixelY[10], pixelY}) - $signed({topLeftY[10], topLeftY});
        in_box = (dx >= 12'sd0) && (dx < W_L) && (dy >= 12'sd0) && (dy < H_L);
    end

    // Registered drawing request and offsets, one cycle behind the pixel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            offsetX        <= '0;
            offsetY        <= '0;
        end else begin
            drawingRequest <= (state == FLYING) && in_box;
            offsetX        <= dx[10:0];
            offsetY        <= dy[10:0];
        end
    end

endmodule

// File: tb/tb_rocket_flight_unit.sv
// Testbench for rocket_flight_unit: directed stimulus pushes expected output
// snapshots into a queue; a monitor pops and compares them on the falling edge.

module tb_rocket_flight_unit;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic               isActive;
    logic signed [10:0] initialSpeed;
    logic signed [10:0] initialX;
    logic signed [10:0] initialY;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               reachedBorder;
    logic               drawingRequest;
    logic        [10:0] offsetX;
    logic        [10:0] offsetY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [5:0]  mask;   // {tlx, tly, rb, dr, ox, oy}
        logic [10:0] tlx;
        logic [10:0] tly;
        logic        rb;
        logic        dr;
        logic [10:0] ox;
        logic [10:0] oy;
    } exp_t;

    exp_t exp_q[$];

    rocket_flight_unit dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .isActive      (isActive),
        .initialSpeed  (initialSpeed),
        .initialX      (initialX),
        .initialY      (initialY),
        .pixelX        (pixelX),
        .pixelY        (pixelY),
        .topLeftX      (topLeftX),
        .topLeftY      (topLeftY),
        .reachedBorder (reachedBorder),
        .drawingRequest(drawingRequest),
        .offsetX       (offsetX),
        .offsetY       (offsetY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string n, input string f, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0d expected=%0d", n, f, act, exp);
        end
    endtask

    // Monitor: compares the oldest expectation against the settled outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.mask[5]) cmp(e.name, "topLeftX",       topLeftX,              e.tlx);
            if (e.mask[4]) cmp(e.name, "topLeftY",       topLeftY,              e.tly);
            if (e.mask[3]) cmp(e.name, "reachedBorder",  {10'd0, reachedBorder}, {10'd0, e.rb});
            if (e.mask[2]) cmp(e.name, "drawingRequest", {10'd0, drawingRequest}, {10'd0, e.dr});
            if (e.mask[1]) cmp(e.name, "offsetX",        offsetX,               e.ox);
            if (e.mask[0]) cmp(e.name, "offsetY",        offsetY,               e.oy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string n);
        int budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s monitor timeout, %0d expectations left, required 0", n, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push(input exp_t e);
        exp_q.push_back(e);
        wait_empty(e.name);
    endtask

    task automatic expect_pos(input string n, input int x, input int y, input logic rb);
        exp_t e;
        e.name = n; e.mask = 6'b111000;
        e.tlx = 11'(x); e.tly = 11'(y); e.rb = rb;
        e.dr = 1'b0; e.ox = '0; e.oy = '0;
        push(e);
    endtask

    task automatic expect_draw(input string n, input logic dr, input int ox, input int oy);
        exp_t e;
        e.name = n; e.mask = 6'b000111;
        e.tlx = '0; e.tly = '0; e.rb = 1'b0;
        e.dr = dr; e.ox = 11'(ox); e.oy = 11'(oy);
        push(e);
    endtask

    task automatic expect_zero(input string n);
        exp_t e;
        e.name = n; e.mask = 6'b111111;
        e.tlx = '0; e.tly = '0; e.rb = 1'b0; e.dr = 1'b0; e.ox = '0; e.oy = '0;
        push(e);
    endtask

    task automatic expect_dr_rb(input string n, input logic dr, input logic rb);
        exp_t e;
        e.name = n; e.mask = 6'b001100;
        e.tlx = '0; e.tly = '0; e.rb = rb; e.dr = dr; e.ox = '0; e.oy = '0;
        push(e);
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    // Drop isActive for one edge, then raise it with new launch values.
    task automatic launch(input int x, input int y, input int spd);
        isActive = 1'b0;
        tick();
        initialX = 11'(x); initialY = 11'(y); initialSpeed = 11'(spd);
        isActive = 1'b1;
        tick();
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; isActive = 1'b0;
        initialSpeed = '0; initialX = '0; initialY = '0;
        pixelX = '0; pixelY = '0;
        #2;
        expect_zero("reset");
        tick();
        resetN = 1'b1;
        tick();

        // Launch at (100,400), speed -3 px/frame.
        launch(100, 400, -192);
        expect_pos("launch", 100, 400, 1'b0);
        frame();
        expect_pos("launch_f1", 100, 397, 1'b0);
        frame();
        frame();
        expect_pos("launch_f3", 100, 391, 1'b0);

        // Drawing inside and just outside the box.
        pixelX = 11'sd102; pixelY = 11'sd395;
        tick();
        expect_draw("draw_in", 1'b1, 2, 4);
        pixelX = 11'sd104;
        tick();
        expect_draw("draw_right_edge", 1'b0, 4, 4);
        pixelX = 11'sd100; pixelY = 11'sd406;
        tick();
        expect_draw("draw_bottom_row", 1'b1, 0, 15);

        // Reset mid-flight with isActive held high, then no launch on release.
        resetN = 1'b0;
        expect_zero("reset_mid_flight");
        tick();
        resetN = 1'b1;
        tick();
        tick();
        tick();
        expect_pos("no_launch_held_high", 0, 0, 1'b0);

        // Fractional speed +1.5 px/frame.
        launch(100, 100, 96);
        expect_pos("frac_launch", 100, 100, 1'b0);
        frame(); expect_pos("frac_f1", 100, 101, 1'b0);
        frame(); expect_pos("frac_f2", 100, 103, 1'b0);
        frame(); expect_pos("frac_f3", 100, 104, 1'b0);
        frame(); expect_pos("frac_f4", 100, 106, 1'b0);

        // Top exit.
        launch(50, 5, -192);
        expect_pos("top_launch", 50, 5, 1'b0);
        frame();
        expect_pos("top_f1", 50, 2, 1'b0);
        pixelX = 11'sd51; pixelY = 11'sd5;
        tick();
        expect_draw("top_draw_flying", 1'b1, 1, 3);
        frame();
        expect_pos("top_f2_done", 50, -1, 1'b1);
        tick();
        expect_dr_rb("top_done_nodraw", 1'b0, 1'b1);
        frame();
        expect_pos("top_done_frozen", 50, -1, 1'b1);
        isActive = 1'b0;
        expect_dr_rb("top_release_same_cycle", 1'b0, 1'b0);

        // Bottom exit (isActive low from above, so this is a fresh rise).
        tick();
        initialX = 11'sd30; initialY = 11'sd460; initialSpeed = 11'sd256;
        isActive = 1'b1;
        tick();
        expect_pos("bot_launch", 30, 460, 1'b0);
        frame(); expect_pos("bot_f1", 30, 464, 1'b0);
        frame(); expect_pos("bot_f2_done", 30, 468, 1'b1);

        // Cancel coinciding with a frame, then immediate relaunch.
        launch(10, 200, -192);
        frame();
        expect_pos("cancel_pre", 10, 197, 1'b0);
        isActive = 1'b0;
        frame();
        expect_pos("cancel_no_move", 10, 197, 1'b0);
        initialX = 11'sd20; initialY = 11'sd300; initialSpeed = 11'sd64;
        isActive = 1'b1;
        tick();
        expect_pos("relaunch", 20, 300, 1'b0);
        frame();
        expect_pos("relaunch_f1", 20, 301, 1'b0);

        // Zero speed stays in flight.
        launch(60, 250, 0);
        frame(); frame(); frame();
        expect_pos("zero_speed", 60, 250, 1'b0);
        pixelX = 11'sd63; pixelY = 11'sd250;
        tick();
        expect_draw("zero_speed_draw", 1'b1, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
